mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch requester (I, read-only) and the memory-stage data requester (D, read/write).
- Sits between the fetch/MEM pipeline stages and the memory interface.
- Honours a D-side lock so that the two back-to-back accesses of LDI/STI (pointer fetch, then data access) are never split by a fetch.
- Latches each granted transaction and bounds fetch starvation.

Parameters:
ADDR_WIDTH, 16, address width of all ports
DATA_WIDTH, 16, data width of all ports
STARVE_LIMIT, 4, consecutive D wins while I waits before I is forced ahead

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_read  in  1  fetch read request, held until i_resp
i_address  in  ADDR_WIDTH  fetch address
i_rdata  out  DATA_WIDTH  fetch read data, valid with i_resp
i_resp  out  1  fetch completion, one-cycle pulse
d_read  in  1  data read request, held until d_resp
d_write  in  1  data write request, held until d_resp
d_lock  in  1  keep port reserved for D (asserted by LDI/STI control across both accesses)
d_address  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  data write value
d_rdata  out  DATA_WIDTH  data read data, valid with d_resp
d_resp  out  1  data completion, one-cycle pulse
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data
mem_resp  in  1  memory completion

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, LOCK_D.
- Reset (rst_n=0, any time, including mid-transaction): state IDLE, starve_cnt=0, latches cleared. All outputs 0 (mem_read, mem_write, mem_address, mem_wdata, i_resp, d_resp, rdata outputs).
- Latches: op (read/write), address, wdata, owner-valid flag.
  - Memory outputs are driven only from the latches and only in SERVE_x.
  - In IDLE and LOCK_D, mem_read=mem_write=0.
- D request: req_d = d_read|d_write. d_read and d_write both high is treated as a write.
- IDLE arbitration:
  - Only req_d: latch D, go to SERVE_D.
  - Only i_read: latch I, go to SERVE_I.
  - Both requesting: D wins unless starve_cnt==STARVE_LIMIT, in which case I wins.
  - Latency: request seen in cycle N gives the mem strobe in cycle N+1.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - Increments, saturating, on each IDLE grant to D while i_read=1.
  - Clears on any grant to I, or in any IDLE cycle with i_read=0.
- SERVE_x:
  - Hold mem signals from the latches until mem_resp.
  - On mem_resp: if the owner's request is still asserted, pulse x_resp for exactly that cycle and pass mem_rdata to x_rdata combinationally. Otherwise (request abandoned, e.g. flush) drop the response: no x_resp.
  - Next state: SERVE_D with d_lock=1 goes to LOCK_D; everything else goes to IDLE.
  - I/D request changes during SERVE_x do not alter the mem outputs.
- LOCK_D:
  - I is never granted.
  - req_d=1: latch D and go to SERVE_D (latency 1, as in IDLE). Not counted by starve_cnt.
  - d_lock=0 with req_d=0: go to IDLE.
  - d_lock=0 with req_d=1: the request is still served (SERVE_D), then IDLE.
- The same-cycle response/request hazard is avoided by design. A requester keeps its request high during its own resp cycle; the arbiter returns to IDLE or LOCK_D first, so a held-over request is only re-granted if it is still asserted in a later cycle. Requesters deassert in the cycle after resp.
- x_rdata holds its last value outside resp cycles (don't-care for checking).

Test Plan:
- Fetch only: i_read=1, addr 0x3000, mem_resp 3 cycles later with rdata 0x1234 -> mem_read=1 and mem_address=0x3000 from cycle 1; i_resp=1 and i_rdata=0x1234 for one cycle; state returns to IDLE.
- Simultaneous i_read and d_write (addr 0x4000, wdata 0xBEEF) -> D granted first (mem_write=1, mem_address=0x4000, mem_wdata=0xBEEF); I is served after d_resp.
- Starvation: i_read held high while D issues 5 consecutive reads -> D wins grants 1–4; the 5th IDLE arbitration grants I; starve_cnt clears to 0.
- LDI lock: d_lock=1, D read 0x5000 returns 0x6000, then D read 0x6000, while i_read=1 throughout -> mem_address sequence 0x5000, 0x6000 with no fetch between; I is granted only after d_lock drops.
- Abandoned request: I granted, i_read dropped before mem_resp -> mem_read stays high until mem_resp; no i_resp is issued.
- Async reset asserted mid-SERVE_D -> all outputs 0 immediately (same cycle, no clock edge); after release the arbiter is in IDLE and re-arbitrates pending requests normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared memory port.
// The arbiter uses the slave view; the pipeline/memory environment uses the master view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic                  d_lock;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_lock, d_address, d_wdata,
               mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_lock, d_address, d_wdata,
               mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and the data stage (D),
// honouring a D-side lock for LDI/STI pairs and bounding fetch starvation.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, LOCK_D} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      starve_cnt, starve_cnt_nxt;
    logic                  lat_write;
    logic                  lat_valid;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

    logic req_d;
    logic grant_i, grant_d;
    logic serving;
    logic i_resp_c, d_resp_c;

    assign req_d   = bus.d_read | bus.d_write;
    assign serving = (state == SERVE_I) || (state == SERVE_D);

    // Completion is forwarded only while the owner still holds its request.
    assign i_resp_c = (state == SERVE_I) && bus.mem_resp && bus.i_read;
    assign d_resp_c = (state == SERVE_D) && bus.mem_resp && req_d;

    // Arbitration and next-state selection.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        grant_i        = 1'b0;
        grant_d        = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_d && !(bus.i_read && (starve_cnt == CNT_W'(STARVE_LIMIT)))) begin
                    grant_d   = 1'b1;
                    state_nxt = SERVE_D;
                end else if (bus.i_read) begin
                    grant_i   = 1'b1;
                    state_nxt = SERVE_I;
                end
                if (!bus.i_read || grant_i) begin
                    starve_cnt_nxt = '0;
                end else if (grant_d && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                    starve_cnt_nxt = starve_cnt + CNT_W'(1);
                end
            end
            SERVE_I: begin
                if (bus.mem_resp) state_nxt = IDLE;
            end
            SERVE_D: begin
                if (bus.mem_resp) state_nxt = bus.d_lock ? LOCK_D : IDLE;
            end
            LOCK_D: begin
                if (req_d) begin
                    grant_d   = 1'b1;
                    state_nxt = SERVE_D;
                end else if (!bus.d_lock) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, starvation counter, transaction latches and read-data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_write  <= 1'b0;
            lat_valid  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            if (grant_i) begin
                lat_write <= 1'b0;
                lat_valid <= 1'b1;
                lat_addr  <= bus.i_address;
                lat_wdata <= '0;
            end else if (grant_d) begin
                lat_write <= bus.d_write;
                lat_valid <= 1'b1;
                lat_addr  <= bus.d_address;
                lat_wdata <= bus.d_wdata;
            end else if (serving && bus.mem_resp) begin
                lat_valid <= 1'b0;
            end
            if (i_resp_c) i_rdata_q <= bus.mem_rdata;
            if (d_resp_c) d_rdata_q <= bus.mem_rdata;
        end
    end

    // Memory side is driven purely from the latches while a transaction is in flight.
    assign bus.mem_read    = serving && lat_valid && !lat_write;
    assign bus.mem_write   = serving && lat_valid && lat_write;
    assign bus.mem_address = serving ? lat_addr  : '0;
    assign bus.mem_wdata   = serving ? lat_wdata : '0;

    assign bus.i_resp  = i_resp_c;
    assign bus.d_resp  = d_resp_c;
    assign bus.i_rdata = i_resp_c ? bus.mem_rdata : i_rdata_q;
    assign bus.d_rdata = d_resp_c ? bus.mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, D priority, starvation bound,
// LDI lock, abandoned fetch and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1 ({tag, "_mem_read"},  bus.mem_read,  1'b0);
        chk1 ({tag, "_mem_write"}, bus.mem_write, 1'b0);
        chk16({tag, "_mem_addr"},  bus.mem_address, 16'h0000);
        chk16({tag, "_mem_wdata"}, bus.mem_wdata, 16'h0000);
        chk1 ({tag, "_i_resp"},    bus.i_resp,    1'b0);
        chk1 ({tag, "_d_resp"},    bus.d_resp,    1'b0);
        chk16({tag, "_i_rdata"},   bus.i_rdata,   16'h0000);
        chk16({tag, "_d_rdata"},   bus.d_rdata,   16'h0000);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.i_read    = 1'b0;
        bus.i_address = 16'h0000;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_lock    = 1'b0;
        bus.d_address = 16'h0000;
        bus.d_wdata   = 16'h0000;
        bus.mem_rdata = 16'h0000;
        bus.mem_resp  = 1'b0;

        cyc(); cyc();
        chk_all_zero("reset");
        chk16("reset_starve", 16'(dut.starve_cnt), 16'd0);
        rst_n = 1'b1;

        // Fetch only: strobe one cycle after request, resp three cycles later.
        cyc();
        bus.i_read = 1'b1; bus.i_address = 16'h3000;
        #1 chk1("f_c0_mem_read", bus.mem_read, 1'b0);
        cyc();
        chk1 ("f_c1_mem_read", bus.mem_read, 1'b1);
        chk16("f_c1_addr", bus.mem_address, 16'h3000);
        chk1 ("f_c1_mem_write", bus.mem_write, 1'b0);
        cyc();
        chk1("f_c2_i_resp", bus.i_resp, 1'b0);
        cyc();
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h1234;
        #1;
        chk1 ("f_i_resp", bus.i_resp, 1'b1);
        chk16("f_i_rdata", bus.i_rdata, 16'h1234);
        chk1 ("f_d_resp", bus.d_resp, 1'b0);
        cyc();
        bus.mem_resp = 1'b0; bus.i_read = 1'b0;
        #1;
        chk1("f_idle_mem_read", bus.mem_read, 1'b0);
        chk1("f_idle_i_resp", bus.i_resp, 1'b0);

        // Simultaneous I read and D write: D first, then I.
        cyc();
        bus.i_read = 1'b1; bus.i_address = 16'h3002;
        bus.d_write = 1'b1; bus.d_address = 16'h4000; bus.d_wdata = 16'hBEEF;
        cyc();
        chk1 ("dw_mem_write", bus.mem_write, 1'b1);
        chk1 ("dw_mem_read", bus.mem_read, 1'b0);
        chk16("dw_addr", bus.mem_address, 16'h4000);
        chk16("dw_wdata", bus.mem_wdata, 16'hBEEF);
        chk16("dw_starve", 16'(dut.starve_cnt), 16'd1);
        bus.mem_resp = 1'b1;
        #1;
        chk1("dw_d_resp", bus.d_resp, 1'b1);
        chk1("dw_i_resp", bus.i_resp, 1'b0);
        cyc();
        bus.mem_resp = 1'b0; bus.d_write = 1'b0;
        #1 chk1("dw_idle_mem_write", bus.mem_write, 1'b0);
        cyc();
        chk1 ("dw_i_mem_read", bus.mem_read, 1'b1);
        chk16("dw_i_addr", bus.mem_address, 16'h3002);
        chk16("dw_i_starve", 16'(dut.starve_cnt), 16'd0);
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h5555;
        #1;
        chk1 ("dw_i_resp", bus.i_resp, 1'b1);
        chk16("dw_i_rdata", bus.i_rdata, 16'h5555);
        cyc();
        bus.mem_resp = 1'b0; bus.i_read = 1'b0;

        // Starvation: D wins four times, the fifth arbitration goes to I.
        cyc();
        bus.i_read = 1'b1; bus.i_address = 16'h3004;
        bus.d_read = 1'b1; bus.d_address = 16'h0100;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk1 ("sv_d_mem_read", bus.mem_read, 1'b1);
            chk16("sv_d_addr", bus.mem_address, 16'h0100 + 16'(k));
            chk16("sv_starve", 16'(dut.starve_cnt), 16'(k + 1));
            bus.mem_resp = 1'b1; bus.mem_rdata = 16'hA000 + 16'(k);
            #1;
            chk1 ("sv_d_resp", bus.d_resp, 1'b1);
            chk16("sv_d_rdata", bus.d_rdata, 16'hA000 + 16'(k));
            cyc();
            bus.mem_resp = 1'b0; bus.d_address = 16'h0101 + 16'(k);
        end
        cyc();
        chk1 ("sv_i_mem_read", bus.mem_read, 1'b1);
        chk16("sv_i_addr", bus.mem_address, 16'h3004);
        chk16("sv_i_starve", 16'(dut.starve_cnt), 16'd0);
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h7777;
        #1;
        chk1("sv_i_resp", bus.i_resp, 1'b1);
        chk1("sv_i_no_d_resp", bus.d_resp, 1'b0);
        cyc();
        bus.mem_resp = 1'b0; bus.i_read = 1'b0;
        cyc();
        chk16("sv_d5_addr", bus.mem_address, 16'h0104);
        chk16("sv_d5_starve", 16'(dut.starve_cnt), 16'd0);
        bus.mem_resp = 1'b1;
        #1 chk1("sv_d5_resp", bus.d_resp, 1'b1);
        cyc();
        bus.mem_resp = 1'b0; bus.d_read = 1'b0;

        // LDI lock: pointer read then data read with no fetch between.
        cyc();
        bus.i_read = 1'b1; bus.i_address = 16'h3006;
        bus.d_read = 1'b1; bus.d_lock = 1'b1; bus.d_address = 16'h5000;
        cyc();
        chk1 ("lk_p_read", bus.mem_read, 1'b1);
        chk16("lk_p_addr", bus.mem_address, 16'h5000);
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h6000;
        #1;
        chk1 ("lk_p_resp", bus.d_resp, 1'b1);
        chk16("lk_p_rdata", bus.d_rdata, 16'h6000);
        cyc();
        bus.mem_resp = 1'b0; bus.d_address = 16'h6000;
        #1 chk1("lk_gap_read", bus.mem_read, 1'b0);
        cyc();
        chk1 ("lk_d_read", bus.mem_read, 1'b1);
        chk16("lk_d_addr", bus.mem_address, 16'h6000);
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h0042;
        #1;
        chk1("lk_d_resp", bus.d_resp, 1'b1);
        chk1("lk_d_no_i_resp", bus.i_resp, 1'b0);
        cyc();
        bus.mem_resp = 1'b0; bus.d_read = 1'b0; bus.d_lock = 1'b0;
        #1 chk1("lk_hold_read", bus.mem_read, 1'b0);
        cyc();
        chk1("lk_idle_read", bus.mem_read, 1'b0);
        cyc();
        chk1 ("lk_i_read", bus.mem_read, 1'b1);
        chk16("lk_i_addr", bus.mem_address, 16'h3006);
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h1111;
        #1 chk1("lk_i_resp", bus.i_resp, 1'b1);
        cyc();
        bus.mem_resp = 1'b0; bus.i_read = 1'b0;

        // Abandoned fetch: strobe held to mem_resp, response dropped.
        cyc();
        bus.i_read = 1'b1; bus.i_address = 16'h3008;
        cyc();
        chk1 ("ab_read", bus.mem_read, 1'b1);
        chk16("ab_addr", bus.mem_address, 16'h3008);
        bus.i_read = 1'b0;
        cyc();
        chk1("ab_read_held", bus.mem_read, 1'b1);
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h9999;
        #1;
        chk1("ab_no_i_resp", bus.i_resp, 1'b0);
        chk1("ab_read_at_resp", bus.mem_read, 1'b1);
        cyc();
        bus.mem_resp = 1'b0;
        #1 chk1("ab_idle_read", bus.mem_read, 1'b0);

        // Asynchronous reset in the middle of a D write.
        cyc();
        bus.d_write = 1'b1; bus.d_address = 16'h4010; bus.d_wdata = 16'hCAFE;
        bus.i_read = 1'b1; bus.i_address = 16'h300A;
        cyc();
        chk1("rs_pre_write", bus.mem_write, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rs_async");
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk1 ("rs_d_write", bus.mem_write, 1'b1);
        chk16("rs_d_addr", bus.mem_address, 16'h4010);
        chk16("rs_d_wdata", bus.mem_wdata, 16'hCAFE);
        bus.mem_resp = 1'b1;
        #1 chk1("rs_d_resp", bus.d_resp, 1'b1);
        cyc();
        bus.mem_resp = 1'b0; bus.d_write = 1'b0;
        cyc();
        chk1 ("rs_i_read", bus.mem_read, 1'b1);
        chk16("rs_i_addr", bus.mem_address, 16'h300A);
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'hABCD;
        #1;
        chk1 ("rs_i_resp", bus.i_resp, 1'b1);
        chk16("rs_i_rdata", bus.i_rdata, 16'hABCD);
        cyc();
        bus.mem_resp = 1'b0; bus.i_read = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
